// File: rtl/exe_stage_mc.sv
// exe_stage_mc: ARM-style execute stage with Val2 shifter, ALU, NZCV
// register and an iterative shift-add multiplier behind valid/ready.
module exe_stage_mc #(
    parameter int WIDTH  = 32,
    parameter int IMM_W  = 24,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             imm_en,
    input  logic             s_en,
    input  logic [3:0]       alu_cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val_rm,
    input  logic [11:0]      shift_operand,
    input  logic [IMM_W-1:0] signed_imm,
    input  logic [WIDTH-1:0] pc,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] branch_addr,
    output logic [3:0]       nzcv
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             mul_s_q, mul_s_d;
    logic [WIDTH-1:0] mul_br_q, mul_br_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [WIDTH-1:0] branch_q, branch_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic             out_valid_q, out_valid_d;

    function automatic logic [WIDTH-1:0] ror_f(
        input logic [WIDTH-1:0] x,
        input int               amt
    );
        int r;
        r = amt % WIDTH;
        if (r == 0) return x;
        return (x >> r) | (x << (WIDTH - r));
    endfunction

    logic [WIDTH-1:0] val2;
    logic [4:0]       sh_amt;

    always_comb begin
        sh_amt = shift_operand[11:7];
        val2   = val_rm;
        if (mem_read || mem_write) begin
            val2 = WIDTH'(shift_operand);
        end else if (imm_en) begin
            val2 = ror_f(WIDTH'(shift_operand[7:0]),
                         2 * int'(shift_operand[11:8]));
        end else begin
            case (shift_operand[6:5])
                2'b00:   val2 = val_rm << sh_amt;
                2'b01:   val2 = val_rm >> sh_amt;
                2'b10:   val2 = $signed(val_rm) >>> sh_amt;
                default: val2 = ror_f(val_rm, int'(sh_amt));
            endcase
        end
    end

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] b_eff;
    logic             c_in;
    logic             arith;
    logic             known;
    logic             is_mul;
    logic             c_flag;
    logic             v_flag;

    always_comb begin
        c_in   = nzcv_q[1];
        sum    = '0;
        res    = '0;
        arith  = 1'b0;
        known  = 1'b1;
        is_mul = 1'b0;
        case (alu_cmd)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010: begin
                sum   = {1'b0, val1} + {1'b0, val2};
                arith = 1'b1;
            end
            4'b0011: begin
                sum   = {1'b0, val1} + {1'b0, val2}
                      + {{WIDTH{1'b0}}, c_in};
                arith = 1'b1;
            end
            4'b0100: begin
                sum   = {1'b0, val1} + {1'b0, ~val2}
                      + {{WIDTH{1'b0}}, 1'b1};
                arith = 1'b1;
            end
            4'b0101: begin
                sum   = {1'b0, val1} + {1'b0, ~val2}
                      + {{WIDTH{1'b0}}, c_in};
                arith = 1'b1;
            end
            4'b0110: res = val1 & val2;
            4'b0111: res = val1 | val2;
            4'b1000: res = val1 ^ val2;
            4'b1010: begin
                if (MUL_EN) is_mul = 1'b1;
                else        known  = 1'b0;
            end
            default: known = 1'b0;
        endcase
        if (arith) res = sum[WIDTH-1:0];
        // Subtraction is val1 + ~val2 + cin, so overflow uses ~val2
        b_eff  = alu_cmd[2] ? ~val2 : val2;
        c_flag = sum[WIDTH];
        v_flag = (val1[MSB] == b_eff[MSB]) && (res[MSB] != val1[MSB]);
    end

    logic             accept;
    logic             mem_op;
    logic [WIDTH-1:0] br_calc;
    logic [WIDTH-1:0] step_acc;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready && !flush;
    assign mem_op   = mem_read || mem_write;
    assign br_calc  = pc + ({{(WIDTH-IMM_W){signed_imm[IMM_W-1]}},
                            signed_imm} << 2);
    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        mul_s_d     = mul_s_q;
        mul_br_d    = mul_br_q;
        alu_out_d   = alu_out_q;
        branch_d    = branch_q;
        nzcv_d      = nzcv_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_d  = S_MUL;
                    cnt_d    = '0;
                    mcand_d  = val1;
                    mplier_d = val2;
                    acc_d    = '0;
                    mul_s_d  = s_en && !mem_op;
                    mul_br_d = br_calc;
                end else if (accept) begin
                    alu_out_d   = res;
                    branch_d    = br_calc;
                    out_valid_d = 1'b1;
                    if (s_en && !mem_op && known) begin
                        nzcv_d[3] = res[MSB];
                        nzcv_d[2] = (res == '0);
                        if (arith) nzcv_d[1:0] = {c_flag, v_flag};
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d    = step_acc;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d     = S_IDLE;
                        alu_out_d   = step_acc;
                        branch_d    = mul_br_q;
                        out_valid_d = 1'b1;
                        if (mul_s_q) begin
                            nzcv_d[3] = step_acc[MSB];
                            nzcv_d[2] = (step_acc == '0);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            mul_s_q     <= 1'b0;
            mul_br_q    <= '0;
            alu_out_q   <= '0;
            branch_q    <= '0;
            nzcv_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            mul_s_q     <= mul_s_d;
            mul_br_q    <= mul_br_d;
            alu_out_q   <= alu_out_d;
            branch_q    <= branch_d;
            nzcv_q      <= nzcv_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_out     = alu_out_q;
    assign branch_addr = branch_q;
    assign nzcv        = nzcv_q;
endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: directed table, multi-cycle sequences and a random
// phase checked against a behavioural model of the execute stage.
module tb_exe_stage_mc;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        mem_read;
    logic        mem_write;
    logic        imm_en;
    logic        s_en;
    logic [3:0]  alu_cmd;
    logic [31:0] val1;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm;
    logic [31:0] pc;
    logic        out_valid;
    logic [31:0] alu_out;
    logic [31:0] branch_addr;
    logic [3:0]  nzcv;

    int checks = 0;
    int errors = 0;

    exe_stage_mc dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .imm_en        (imm_en),
        .s_en          (s_en),
        .alu_cmd       (alu_cmd),
        .val1          (val1),
        .val_rm        (val_rm),
        .shift_operand (shift_operand),
        .signed_imm    (signed_imm),
        .pc            (pc),
        .out_valid     (out_valid),
        .alu_out       (alu_out),
        .branch_addr   (branch_addr),
        .nzcv          (nzcv)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  cmd;
        logic        s;
        logic        imm;
        logic        mem;
        logic [31:0] a;
        logic [31:0] rm;
        logic [11:0] so;
        logic [31:0] p;
        logic [23:0] si;
        logic [31:0] e_alu;
        logic [3:0]  e_f;
        logic [31:0] e_br;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic s,
                         input logic imm, input logic mw,
                         input logic mr, input logic [31:0] a,
                         input logic [31:0] rm, input logic [11:0] so,
                         input logic [31:0] p, input logic [23:0] si);
        alu_cmd       = cmd;
        s_en          = s;
        imm_en        = imm;
        mem_write     = mw;
        mem_read      = mr;
        val1          = a;
        val_rm        = rm;
        shift_operand = so;
        pc            = p;
        signed_imm    = si;
        in_valid      = 1'b1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] ea,
                             input logic [3:0] ef, input logic [31:0] eb);
        chk({tag, ".alu"}, 64'(alu_out), 64'(ea));
        chk({tag, ".nzcv"}, 64'(nzcv), 64'(ef));
        chk({tag, ".br"}, 64'(branch_addr), 64'(eb));
    endtask

    function automatic logic [31:0] m_val2(input logic mem, input logic imm,
                                           input logic [31:0] rm,
                                           input logic [11:0] so);
        longint unsigned x;
        longint unsigned p2;
        longint          sx;
        int              amt;
        if (mem) return 32'(so);
        if (imm) begin
            x   = {32'(so[7:0]), 32'(so[7:0])};
            amt = 2 * int'(so[11:8]);
            x   = x >> amt;
            return x[31:0];
        end
        amt = int'(so[11:7]);
        p2  = 64'd1 << amt;
        x   = 64'(rm);
        case (so[6:5])
            2'b00: x = x * p2;
            2'b01: x = x / p2;
            2'b10: begin
                sx = $signed(rm);
                sx = sx >>> amt;
                x  = sx;
            end
            default: begin
                x = {rm, rm};
                x = x >> amt;
            end
        endcase
        return x[31:0];
    endfunction

    task automatic m_alu(input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] fin,
                         input logic upd, output logic [31:0] r,
                         output logic [3:0] f);
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned u;
        longint          sa;
        longint          sb;
        longint          sr;
        int              ci;
        logic            arith;
        logic            known;
        logic            cout;
        ua = 64'(a);
        ub = 64'(b);
        sa = $signed(a);
        sb = $signed(b);
        ci = int'(fin[1]);
        sr = 0;
        arith = 1'b0;
        known = 1'b1;
        cout = 1'b0;
        r = '0;
        case (cmd)
            4'd1: r = b;
            4'd9: r = ~b;
            4'd2, 4'd3: begin
                u = ua + ub + ((cmd == 4'd3) ? 64'(ci) : 64'd0);
                sr = sa + sb + ((cmd == 4'd3) ? longint'(ci) : 0);
                cout = (u >= 64'h1_0000_0000);
                r = u[31:0];
                arith = 1'b1;
            end
            4'd4, 4'd5: begin
                u = ub + ((cmd == 4'd5) ? 64'(1 - ci) : 64'd0);
                sr = sa - sb - ((cmd == 4'd5) ? longint'(1 - ci) : 0);
                cout = (ua >= u);
                r = a - u[31:0];
                arith = 1'b1;
            end
            4'd6: r = a & b;
            4'd7: r = a | b;
            4'd8: r = a ^ b;
            4'd10: begin
                u = ua * ub;
                r = u[31:0];
            end
            default: known = 1'b0;
        endcase
        f = fin;
        if (upd && known) begin
            f[3] = r[31];
            f[2] = (r == 32'd0);
            if (arith) begin
                f[1] = cout;
                f[0] = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
        end
    endtask

    logic [3:0]  m_f;
    logic [31:0] m_alu_v;
    logic [31:0] m_br;
    logic [3:0]  r_cmd;
    logic        r_s;
    logic        r_imm;
    logic        r_mw;
    logic        r_mr;
    logic [31:0] r_a;
    logic [31:0] r_rm;
    logic [11:0] r_so;
    logic [31:0] r_pc;
    logic [23:0] r_si;
    logic [31:0] e_res;
    logic [3:0]  e_f;
    logic [31:0] e_br;
    int          n;
    int          lows;
    int          pulses;

    initial begin
        tbl[0]  = '{4'd2, 1, 1, 0, 32'h7FFFFFFF, 32'h0, 12'h001,
                    32'h0, 24'h0, 32'h80000000, 4'b1001, 32'h0};
        tbl[1]  = '{4'd4, 1, 0, 0, 32'd5, 32'd5, 12'h000,
                    32'h0, 24'h0, 32'h0, 4'b0110, 32'h0};
        tbl[2]  = '{4'd3, 0, 0, 0, 32'd1, 32'd1, 12'h000,
                    32'h0, 24'h0, 32'd3, 4'b0110, 32'h0};
        tbl[3]  = '{4'd2, 1, 0, 1, 32'h100, 32'h0, 12'hFFC,
                    32'h40, 24'hFFFFFF, 32'h10FC, 4'b0110, 32'h3C};
        tbl[4]  = '{4'd1, 1, 1, 0, 32'h0, 32'h0, 12'h4FF,
                    32'h1000, 24'h10, 32'hFF000000, 4'b1010, 32'h1040};
        tbl[5]  = '{4'd9, 1, 0, 0, 32'h0, 32'hFFFFFFFF, 12'h000,
                    32'h0, 24'h0, 32'h0, 4'b0110, 32'h0};
        tbl[6]  = '{4'd7, 0, 0, 0, 32'hF00, 32'h1, 12'h200,
                    32'h0, 24'h0, 32'hF10, 4'b0110, 32'h0};
        tbl[7]  = '{4'd6, 1, 0, 0, 32'hFFFFFFFF, 32'h80000000, 12'hFC0,
                    32'h0, 24'h0, 32'hFFFFFFFF, 4'b1010, 32'h0};
        tbl[8]  = '{4'd8, 1, 0, 0, 32'h12345678, 32'hF1, 12'h260,
                    32'h0, 24'h0, 32'h02345677, 4'b0010, 32'h0};
        tbl[9]  = '{4'd5, 1, 0, 0, 32'd10, 32'd3, 12'h0A0,
                    32'h80000000, 24'h800000, 32'd9, 4'b0010, 32'h7E000000};
        tbl[10] = '{4'd4, 1, 0, 0, 32'd0, 32'd1, 12'h000,
                    32'h0, 24'h0, 32'hFFFFFFFF, 4'b1000, 32'h0};
        tbl[11] = '{4'd5, 1, 0, 0, 32'd5, 32'd1, 12'h000,
                    32'h0, 24'h0, 32'd3, 4'b0010, 32'h0};
        tbl[12] = '{4'd2, 1, 0, 0, 32'h80000000, 32'h80000000, 12'h000,
                    32'h0, 24'h0, 32'h0, 4'b0111, 32'h0};
        tbl[13] = '{4'd0, 1, 0, 0, 32'd5, 32'd5, 12'h000,
                    32'h0, 24'h0, 32'h0, 4'b0111, 32'h0};
        tbl[14] = '{4'd15, 1, 0, 0, 32'd7, 32'd9, 12'h000,
                    32'h0, 24'h0, 32'h0, 4'b0111, 32'h0};
        tbl[15] = '{4'd1, 1, 0, 0, 32'h0, 32'h80000001, 12'h060,
                    32'h0, 24'h0, 32'h80000001, 4'b1011, 32'h0};

        rst = 1'b1;
        flush = 1'b0;
        drive(4'd2, 1, 0, 0, 0, 32'd1, 32'd1, 12'h0, 32'h10, 24'h1);
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk_state("rst", 32'h0, 4'h0, 32'h0);
        rst = 1'b0;
        tick();
        chk("idle.out_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].cmd, tbl[i].s, tbl[i].imm, tbl[i].mem, 1'b0,
                  tbl[i].a, tbl[i].rm, tbl[i].so, tbl[i].p, tbl[i].si);
            tick();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d.ov", i), 64'(out_valid), 64'd1);
            chk_state($sformatf("tbl%0d", i), tbl[i].e_alu, tbl[i].e_f,
                      tbl[i].e_br);
        end
        tick();
        chk("tbl.ov_drop", 64'(out_valid), 64'd0);

        drive(4'd10, 1, 0, 0, 0, 32'h10000, 32'h10000, 12'h0,
              32'h200, 24'h1);
        tick();
        drive(4'd2, 1, 0, 0, 0, 32'd1, 32'd2, 12'h0, 32'h0, 24'h0);
        lows = 0;
        pulses = 0;
        for (int k = 1; k <= W; k++) begin
            if (!in_ready) lows++;
            if (out_valid) pulses++;
            tick();
        end
        in_valid = 1'b0;
        chk("mul4.ready_low", 64'(lows), 64'(W));
        chk("mul4.early_ov", 64'(pulses), 64'd0);
        chk("mul4.ov", 64'(out_valid), 64'd1);
        chk("mul4.ready", 64'(in_ready), 64'd1);
        chk_state("mul4", 32'h0, 4'b0111, 32'h204);
        tick();
        chk("mul4.ov_drop", 64'(out_valid), 64'd0);
        chk("mul4.busy_ign", 64'(alu_out), 64'd0);

        drive(4'd10, 1, 0, 0, 0, 32'd3, 32'd4, 12'h0, 32'h300, 24'h0);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("mul5.ready", 64'(in_ready), 64'd1);
        pulses = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (out_valid) pulses++;
            tick();
        end
        chk("mul5.no_ov", 64'(pulses), 64'd0);
        chk_state("mul5", 32'h0, 4'b0111, 32'h204);

        drive(4'd2, 1, 0, 0, 0, 32'd1, 32'd1, 12'h0, 32'h400, 24'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flacc.ov", 64'(out_valid), 64'd0);
        chk_state("flacc", 32'h0, 4'b0111, 32'h204);

        drive(4'd10, 1, 0, 0, 0, 32'd3, 32'd4, 12'h0, 32'h300, 24'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flmul.ready", 64'(in_ready), 64'd1);

        drive(4'd10, 1, 0, 0, 0, 32'd3, 32'd4, 12'h0, 32'h300, 24'h0);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < W + 8) begin
            tick();
            n++;
        end
        chk("mul34.lat", 64'(n), 64'(W));
        chk_state("mul34", 32'd12, 4'b0011, 32'h300);

        m_f = 4'b0011;
        m_alu_v = 32'd12;
        m_br = 32'h300;
        for (int i = 0; i < 300; i++) begin
            r_cmd = 4'($urandom_range(0, 15));
            if (r_cmd == 4'd10 && $urandom_range(0, 2) != 0) r_cmd = 4'd3;
            r_s = 1'($urandom_range(0, 1));
            r_imm = 1'($urandom_range(0, 1));
            r_mw = ($urandom_range(0, 9) == 0);
            r_mr = !r_mw && ($urandom_range(0, 9) == 0);
            r_a = $urandom;
            r_rm = ($urandom_range(0, 4) == 0) ? r_a : $urandom;
            r_so = 12'($urandom);
            r_pc = $urandom;
            r_si = 24'($urandom);
            m_alu(r_cmd, r_a, m_val2(r_mw | r_mr, r_imm, r_rm, r_so), m_f,
                  r_s && !(r_mw | r_mr), e_res, e_f);
            e_br = r_pc + ({{8{r_si[23]}}, r_si} * 4);
            drive(r_cmd, r_s, r_imm, r_mw, r_mr, r_a, r_rm, r_so,
                  r_pc, r_si);
            tick();
            in_valid = 1'b0;
            if (r_cmd == 4'd10) begin
                n = 0;
                while (!out_valid && n < W + 8) begin
                    tick();
                    n++;
                end
                chk($sformatf("rnd%0d.lat", i), 64'(n), 64'(W));
            end else begin
                chk($sformatf("rnd%0d.ov", i), 64'(out_valid), 64'd1);
            end
            chk_state($sformatf("rnd%0d", i), e_res, e_f, e_br);
            m_f = e_f;
            m_alu_v = e_res;
            m_br = e_br;
            if ($urandom_range(0, 3) == 0) begin
                tick();
                chk($sformatf("rnd%0d.gap", i), 64'(out_valid), 64'd0);
                chk_state($sformatf("rnd%0d.hold", i), m_alu_v, m_f, m_br);
            end
        end

        drive(4'd10, 1, 0, 0, 0, 32'd5, 32'd6, 12'h0, 32'h0, 24'h0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        flush = 1'b1;
        drive(4'd2, 1, 0, 0, 0, 32'd1, 32'd1, 12'h0, 32'h50, 24'h1);
        tick();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("rst2.ov", 64'(out_valid), 64'd0);
        chk("rst2.ready", 64'(in_ready), 64'd1);
        chk_state("rst2", 32'h0, 4'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
